conv_param: RTL and testbench

- Parametrised successor to the fixed 12x5 1-D convolution engine.
- Per iteration, accepts an N-sample signed input vector x and an M-tap signed filter f over independent valid/ready streams.
- Produces the N-M+1 valid-mode convolution outputs y[k] = sum_{j=0..M-1} x[k+j]*f[j] on a valid/ready output stream.
- Adds an optional per-iteration ReLU mode. Sits between the input stream buffers and the downstream accumulation/writeback logic.

---
 rtl/conv_param.sv | 155 +++++++++++++++
 tb/tb_conv_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_param.sv
// conv_param: parametrised valid-mode 1-D convolution engine.
// Loads N samples and M taps, then streams N-M+1 results with optional ReLU.
module conv_param #(
    parameter  int N  = 12,
    parameter  int M  = 5,
    parameter  int T  = 10,
    localparam int YW = 2*T + $clog2(M)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic signed [T-1:0]  x_data,
    input  logic                 x_valid,
    output logic                 x_ready,
    input  logic signed [T-1:0]  f_data,
    input  logic                 f_valid,
    output logic                 f_ready,
    input  logic                 relu_en,
    output logic signed [YW-1:0] y_data,
    output logic                 y_valid,
    input  logic                 y_ready
);

    localparam int CW = $clog2(N+1);
    localparam int XW = $clog2(N);
    localparam int FW = $clog2(M);
    localparam int GW = YW - 2*T;
    localparam logic [CW-1:0] NC = CW'(N);
    localparam logic [CW-1:0] MC = CW'(M);
    localparam logic [CW-1:0] KL = CW'(N-M);

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t                r_state;
    logic signed [T-1:0]   r_x [N];
    logic signed [T-1:0]   r_f [M];
    logic [CW-1:0]         r_xcnt;
    logic [CW-1:0]         r_fcnt;
    logic [CW-1:0]         r_k;
    logic [CW-1:0]         r_j;
    logic signed [2*T-1:0] r_prod;
    logic signed [YW-1:0]  r_acc;
    logic signed [YW-1:0]  r_y;
    logic                  r_mode;
    logic                  r_xready;
    logic                  r_fready;
    logic                  r_yvalid;

    logic                  w_xacc;
    logic                  w_facc;
    logic [CW-1:0]         w_xcnt_nx;
    logic [CW-1:0]         w_fcnt_nx;
    logic [CW-1:0]         w_jc;
    logic [XW-1:0]         w_xi;
    logic [FW-1:0]         w_fi;
    logic signed [2*T-1:0] w_xe;
    logic signed [2*T-1:0] w_fe;
    logic signed [2*T-1:0] w_prod;
    logic signed [YW-1:0]  w_sum;
    logic signed [YW-1:0]  w_res;

    assign w_xacc    = x_valid && r_xready;
    assign w_facc    = f_valid && r_fready;
    assign w_xcnt_nx = r_xcnt + CW'(w_xacc);
    assign w_fcnt_nx = r_fcnt + CW'(w_facc);

    // Tap index is clamped on the drain cycle (r_j == M) so the
    // operand fetch never runs past the end of the stores.
    assign w_jc   = (r_j == MC) ? '0 : r_j;
    assign w_xi   = XW'(r_k + w_jc);
    assign w_fi   = FW'(w_jc);
    assign w_xe   = (2*T)'(r_x[w_xi]);
    assign w_fe   = (2*T)'(r_f[w_fi]);
    assign w_prod = w_xe * w_fe;

    // Product is registered, so the final sum adds the last product
    // on the drain cycle; ReLU clamps negatives when the mode bit is set.
    assign w_sum = r_acc + {{GW{r_prod[2*T-1]}}, r_prod};
    assign w_res = (r_mode && w_sum[YW-1]) ? '0 : w_sum;

    assign x_ready = r_xready;
    assign f_ready = r_fready;
    assign y_valid = r_yvalid;
    assign y_data  = r_y;

    // Load / MAC / output sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_LOAD;
            r_xcnt   <= '0;
            r_fcnt   <= '0;
            r_k      <= '0;
            r_j      <= '0;
            r_prod   <= '0;
            r_acc    <= '0;
            r_y      <= '0;
            r_mode   <= 1'b0;
            r_xready <= 1'b0;
            r_fready <= 1'b0;
            r_yvalid <= 1'b0;
            for (int i = 0; i < N; i++) r_x[i] <= '0;
            for (int i = 0; i < M; i++) r_f[i] <= '0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_xacc) r_x[r_xcnt[XW-1:0]] <= x_data;
                    if (w_facc) r_f[r_fcnt[FW-1:0]] <= f_data;
                    r_xcnt   <= w_xcnt_nx;
                    r_fcnt   <= w_fcnt_nx;
                    r_xready <= (w_xcnt_nx != NC);
                    r_fready <= (w_fcnt_nx != MC);
                    if (r_xcnt == NC && r_fcnt == MC) begin
                        r_state <= S_COMPUTE;
                        r_mode  <= relu_en;
                        r_k     <= '0;
                        r_j     <= '0;
                    end
                end
                S_COMPUTE: begin
                    r_prod <= w_prod;
                    r_acc  <= (r_j == '0) ? '0 : w_sum;
                    if (r_j == MC) begin
                        r_y      <= w_res;
                        r_yvalid <= 1'b1;
                        r_state  <= S_OUTPUT;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (y_ready) begin
                        r_yvalid <= 1'b0;
                        r_j      <= '0;
                        if (r_k != KL) begin
                            r_k     <= r_k + 1'b1;
                            r_state <= S_COMPUTE;
                        end else begin
                            r_k      <= '0;
                            r_xcnt   <= '0;
                            r_fcnt   <= '0;
                            r_xready <= 1'b1;
                            r_fready <= 1'b1;
                            r_state  <= S_LOAD;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_param.sv
// tb_conv_param: directed and random stimulus for conv_param.
// Expected outputs come from hand values or a bench-side model.
module tb_conv_param;

    localparam int N  = 12;
    localparam int M  = 5;
    localparam int T  = 10;
    localparam int NO = N - M + 1;
    localparam int YW = 2*T + $clog2(M);

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic signed [T-1:0]  x_data;
    logic                 x_valid;
    logic                 x_ready;
    logic signed [T-1:0]  f_data;
    logic                 f_valid;
    logic                 f_ready;
    logic                 relu_en;
    logic signed [YW-1:0] y_data;
    logic                 y_valid;
    logic                 y_ready;

    int n_err = 0;
    int n_chk = 0;

    int xv [N];
    int fv [M];
    int ev [NO];

    int ord, pv, pr, hold_n, abort_at;
    bit x_done, f_done, loaded, relu_v;

    conv_param #(.N(N), .M(M), .T(T)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .x_data  (x_data),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .f_data  (f_data),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .relu_en (relu_en),
        .y_data  (y_data),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int k, input bit r);
        int s = 0;
        for (int j = 0; j < M; j++) s += xv[k+j] * fv[j];
        if (r && s < 0) s = 0;
        return s;
    endfunction

    task automatic drive_x();
        int i = 0;
        int g = 0;
        while (ord == 2 && !f_done && g < 2000) begin
            @(negedge clk);
            g++;
        end
        while (i < N && g < 5000) begin
            @(negedge clk);
            g++;
            if ($urandom_range(99) < pv) begin
                x_valid = 1'b1;
                x_data  = T'(xv[i]);
            end else begin
                x_valid = 1'b0;
                x_data  = 'x;
            end
            if (x_valid && x_ready) i++;
        end
        if (i < N) check("x_timeout", i, N);
        x_done = 1'b1;
        while (!f_done && g < 5000) begin
            @(negedge clk);
            g++;
            x_valid = 1'b1;
            x_data  = 10'sh155;
        end
        @(negedge clk);
        x_valid = 1'b0;
        x_data  = 'x;
    endtask

    task automatic drive_f();
        int i = 0;
        int g = 0;
        while (ord == 1 && !x_done && g < 2000) begin
            @(negedge clk);
            g++;
        end
        while (i < M && g < 5000) begin
            @(negedge clk);
            g++;
            if ($urandom_range(99) < pv) begin
                f_valid = 1'b1;
                f_data  = T'(fv[i]);
            end else begin
                f_valid = 1'b0;
                f_data  = 'x;
            end
            if (f_valid && f_ready) i++;
        end
        if (i < M) check("f_timeout", i, M);
        @(negedge clk);
        f_valid = 1'b0;
        f_data  = 'x;
        f_done  = 1'b1;
    endtask

    task automatic collect();
        int o = 0;
        int g = 0;
        bit stall = 1'b0;
        bit aborted = 1'b0;
        logic signed [YW-1:0] last = '0;
        while (o < NO && g < 20000 && !aborted) begin
            @(negedge clk);
            g++;
            if (loaded) relu_en = 1'($urandom_range(1));
            if (stall) begin
                check("hold_valid", int'(y_valid), 1);
                check("hold_data", int'(y_data), int'(last));
            end
            if (hold_n > 0 && y_valid) begin
                y_ready = 1'b0;
                hold_n--;
            end else begin
                y_ready = ($urandom_range(99) < pr);
            end
            if (y_valid && y_ready) begin
                check($sformatf("y%0d", o), int'(y_data), ev[o]);
                o++;
                if (o == abort_at) aborted = 1'b1;
            end
            stall = y_valid && !y_ready;
            last  = y_data;
        end
        if (aborted) begin
            y_ready = 1'b0;
            g = 0;
            while (!y_valid && g < 100) begin
                @(negedge clk);
                g++;
            end
            check("pre_rst_valid", int'(y_valid), 1);
            #2 reset_n = 1'b0;
            #1;
            check("rst_y_valid", int'(y_valid), 0);
            check("rst_y_data", int'(y_data), 0);
            check("rst_x_ready", int'(x_ready), 0);
            check("rst_f_ready", int'(f_ready), 0);
        end else begin
            if (o < NO) check("y_timeout", o, NO);
            @(negedge clk);
            check("end_x_ready", int'(x_ready), 1);
            check("end_f_ready", int'(f_ready), 1);
        end
    endtask

    task automatic run_iter(input int o_, input int pv_, input int pr_,
                            input int hold_, input int abort_,
                            input bit relu_);
        ord      = o_;
        pv       = pv_;
        pr       = pr_;
        hold_n   = hold_;
        abort_at = abort_;
        relu_v   = relu_;
        relu_en  = relu_;
        x_done   = 1'b0;
        f_done   = 1'b0;
        loaded   = 1'b0;
        fork
            begin
                fork
                    drive_x();
                    drive_f();
                join
                repeat (2) @(posedge clk);
                loaded = 1'b1;
            end
            collect();
        join
        loaded  = 1'b0;
        relu_en = relu_;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < N; i++) xv[i] = i + 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        x_valid = 1'b0;
        f_valid = 1'b0;
        x_data  = 'x;
        f_data  = 'x;
        relu_en = 1'b0;
        y_ready = 1'b0;
        #23;
        check("rst_x_ready0", int'(x_ready), 0);
        check("rst_f_ready0", int'(f_ready), 0);
        check("rst_y_valid0", int'(y_valid), 0);
        check("rst_y_data0", int'(y_data), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("load_x_ready", int'(x_ready), 1);
        check("load_f_ready", int'(f_ready), 1);

        set_ramp();
        for (int j = 0; j < M; j++) fv[j] = 1;
        for (int k = 0; k < NO; k++) ev[k] = 15 + 5*k;
        run_iter(0, 100, 100, 0, -1, 1'b0);

        for (int j = 0; j < M; j++) fv[j] = -1;
        for (int k = 0; k < NO; k++) ev[k] = -(15 + 5*k);
        run_iter(1, 100, 100, 0, -1, 1'b0);

        for (int k = 0; k < NO; k++) ev[k] = 0;
        run_iter(2, 100, 100, 0, -1, 1'b1);

        for (int i = 0; i < N; i++) xv[i] = -512;
        for (int j = 0; j < M; j++) fv[j] = -512;
        for (int k = 0; k < NO; k++) ev[k] = 1310720;
        run_iter(0, 100, 100, 0, -1, 1'b0);

        for (int j = 0; j < M; j++) fv[j] = 511;
        for (int k = 0; k < NO; k++) ev[k] = -1308160;
        run_iter(0, 100, 100, 0, -1, 1'b0);

        set_ramp();
        for (int j = 0; j < M; j++) fv[j] = 1;
        for (int k = 0; k < NO; k++) ev[k] = 15 + 5*k;
        run_iter(0, 100, 100, 20, -1, 1'b0);

        run_iter(0, 50, 50, 0, -1, 1'b0);

        run_iter(0, 100, 100, 0, 3, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_iter(0, 100, 100, 0, -1, 1'b0);

        for (int it = 0; it < 100; it++) begin
            bit r;
            r = 1'($urandom_range(1));
            for (int i = 0; i < N; i++)
                xv[i] = int'($urandom_range(1023)) - 512;
            for (int j = 0; j < M; j++)
                fv[j] = int'($urandom_range(1023)) - 512;
            for (int k = 0; k < NO; k++) ev[k] = model(k, r);
            run_iter(int'($urandom_range(2)), 50, 50, 0, -1, r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
